keccak_arbiter: RTL

Round-robin controller that shares one `keccak` hashing core between two message requesters. It grants the core to one requester at a time, pulses the core's reset before each message, and forwards that requester's 32-bit word stream under `buffer_full` back-pressure. It then waits for `out_ready`, captures the 512-bit digest, and returns it to the owner with a done pulse. It sits between the system-side message sources and the single `keccak` instance.

---
 rtl/keccak_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/keccak_arbiter.sv
// Round-robin arbiter sharing one keccak core between two message requesters.
// Grants the core, pulses its reset, forwards words under back-pressure and returns the digest.
module keccak_arbiter #(
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  rq_in0,
    input  logic [31:0]  rq_in1,
    input  logic         rq_valid0,
    input  logic         rq_valid1,
    input  logic         rq_last0,
    input  logic         rq_last1,
    input  logic [1:0]   rq_bytes0,
    input  logic [1:0]   rq_bytes1,
    output logic         rq_ready0,
    output logic         rq_ready1,
    output logic [1:0]   done,
    output logic [1:0]   err,
    output logic [511:0] digest,
    output logic         core_reset,
    output logic [31:0]  core_in,
    output logic         core_in_ready,
    output logic         core_is_last,
    output logic [1:0]   core_byte_num,
    input  logic         core_buffer_full,
    input  logic [511:0] core_out,
    input  logic         core_out_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_grant;
    logic            r_lastServed;
    logic [511:0]    r_digest;
    logic [CW-1:0]   r_count;

    logic            w_stream;
    logic            w_validG;
    logic            w_lastG;
    logic [1:0]      w_bytesG;
    logic [31:0]     w_inG;
    logic            w_readyG;
    logic            w_accept;
    logic            w_timeout;

    // Word path is purely combinational: the granted requester talks straight to the core.
    assign w_stream  = (r_state == S_STREAM);
    assign w_validG  = r_grant ? rq_valid1 : rq_valid0;
    assign w_lastG   = r_grant ? rq_last1  : rq_last0;
    assign w_bytesG  = r_grant ? rq_bytes1 : rq_bytes0;
    assign w_inG     = r_grant ? rq_in1    : rq_in0;
    assign w_readyG  = w_stream & ~core_buffer_full;
    assign w_accept  = w_readyG & w_validG;
    assign w_timeout = (r_state == S_WAIT) & ~core_out_ready & (r_count == LIMIT);

    assign rq_ready0     = w_readyG & ~r_grant;
    assign rq_ready1     = w_readyG & r_grant;
    assign core_in_ready = w_accept;
    assign core_in       = w_stream ? w_inG : 32'h0;
    assign core_is_last  = w_lastG & w_accept;
    assign core_byte_num = (w_stream & w_lastG) ? w_bytesG : 2'b00;
    assign core_reset    = ~reset | (r_state == S_CLEAR);
    assign done          = (r_state == S_DONE) ? {r_grant, ~r_grant} : 2'b00;
    assign err           = w_timeout ? {r_grant, ~r_grant} : 2'b00;
    assign digest        = r_digest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_lastServed <= 1'b1;
            r_digest     <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rq_valid0 | rq_valid1) begin
                        r_grant <= (rq_valid0 & rq_valid1) ? ~r_lastServed : rq_valid1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: r_state <= S_STREAM;
                S_STREAM: begin
                    if (w_accept & w_lastG) begin
                        r_count <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A timed-out job still counts as served so the other side gets its turn.
                    if (core_out_ready) begin
                        r_digest     <= core_out;
                        r_lastServed <= r_grant;
                        r_state      <= S_DONE;
                    end else if (r_count == LIMIT) begin
                        r_lastServed <= r_grant;
                        r_state      <= S_IDLE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
